pulse_pacer: RTL and testbench

Multi-channel, single-clock pulse regulator. Each channel accepts one-cycle event pulses, including back-to-back bursts that a plain toggle-based pulse crossing would lose. It queues them in a per-channel saturating pending counter and replays them as output events spaced at least GAP cycles apart. It sits in front of slow consumers (toggle synchronisers, interrupt logic, slow-domain counters) that cannot accept events on consecutive cycles.

---
 rtl/pulse_pacer_if.sv | 23 ++
 rtl/pulse_pacer.sv | 84 ++++++++
 tb/tb_pulse_pacer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_pacer_if.sv
// Event pulse bundle for pulse_pacer: per-channel request pulses in, paced
// events and per-channel status out.
interface pulse_pacer_if #(
  parameter int N  = 4,
  parameter int CW = 4
);
  logic [N-1:0]    din;
  logic            clr;
  logic [N-1:0]    dout;
  logic [N*CW-1:0] pending;
  logic [N-1:0]    busy;
  logic [N-1:0]    overflow;

  modport master (
    output din, clr,
    input  dout, pending, busy, overflow
  );

  modport slave (
    input  din, clr,
    output dout, pending, busy, overflow
  );
endinterface

// File: rtl/pulse_pacer.sv
// Multi-channel pulse regulator: queues one-cycle events in a saturating
// per-channel counter and replays them at least GAP cycles apart.
module pulse_pacer #(
  parameter int N    = 4,
  parameter int CW   = 4,
  parameter int GAP  = 3,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          nreset,
  pulse_pacer_if.slave  bus
);

  localparam int            TW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(GAP - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic [N-1:0]    dout_v;
  logic [N-1:0]    busy_v;
  logic [N-1:0]    ovf_v;
  logic [N*CW-1:0] pend_v;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [TW-1:0] tmr;
    logic          ovf;
    logic          emit;
    logic          drop;

    // Emission depends only on state, so a new din never short-circuits to dout.
    assign emit = (cnt != '0) && (tmr == '0);
    assign drop = bus.din[i] && !emit && (cnt == CNT_MAX);

    always_comb begin
      // NOTE: default first so every path assigns cnt_nxt and no latch is inferred.
      cnt_nxt = cnt;
      if (bus.din[i] && !emit) begin
        if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_ONE;
      end else if (!bus.din[i] && emit) begin
        cnt_nxt = cnt - CNT_ONE;
      end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        cnt <= '0;
        tmr <= '0;
        ovf <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        if (emit)              tmr <= TMR_LOAD;
        else if (tmr != '0)    tmr <= tmr - TMR_ONE;
        // A drop in the same cycle as clr must still be recorded.
        if (drop)              ovf <= 1'b1;
        else if (bus.clr)      ovf <= 1'b0;
      end
    end

    if (MODE == 1) begin : g_toggle
      logic tog;
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)   tog <= 1'b0;
        else if (emit) tog <= ~tog;
      end
      assign dout_v[i] = tog;
    end else begin : g_pulse
      assign dout_v[i] = emit;
    end

    assign busy_v[i]           = (cnt != '0) || (tmr != '0);
    assign ovf_v[i]            = ovf;
    assign pend_v[i*CW +: CW]  = cnt;
  end

  assign bus.dout     = dout_v;
  assign bus.busy     = busy_v;
  assign bus.overflow = ovf_v;
  assign bus.pending  = pend_v;

endmodule

// File: tb/tb_pulse_pacer.sv
// Scoreboard bench for pulse_pacer: four configurations side by side, directed
// vectors push expected event cycles, a negedge monitor pops and compares them.
module tb_pulse_pacer;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a: default, b: CW=2, c: GAP=1, d: MODE=1 GAP=2
  pulse_pacer_if #(.N(4), .CW(4)) ifa ();
  pulse_pacer_if #(.N(4), .CW(2)) ifb ();
  pulse_pacer_if #(.N(4), .CW(4)) ifc ();
  pulse_pacer_if #(.N(4), .CW(4)) ifd ();

  pulse_pacer #(.N(4), .CW(4), .GAP(3), .MODE(0)) u_a (.clk(clk), .nreset(nreset), .bus(ifa));
  pulse_pacer #(.N(4), .CW(2), .GAP(3), .MODE(0)) u_b (.clk(clk), .nreset(nreset), .bus(ifb));
  pulse_pacer #(.N(4), .CW(4), .GAP(1), .MODE(0)) u_c (.clk(clk), .nreset(nreset), .bus(ifc));
  pulse_pacer #(.N(4), .CW(4), .GAP(2), .MODE(1)) u_d (.clk(clk), .nreset(nreset), .bus(ifd));

  logic [3:0]  dout_w [4];
  logic [3:0]  busy_w [4];
  logic [3:0]  ovf_w  [4];
  logic [15:0] pend_w [4];

  assign dout_w[0] = ifa.dout;  assign busy_w[0] = ifa.busy;  assign ovf_w[0] = ifa.overflow;
  assign dout_w[1] = ifb.dout;  assign busy_w[1] = ifb.busy;  assign ovf_w[1] = ifb.overflow;
  assign dout_w[2] = ifc.dout;  assign busy_w[2] = ifc.busy;  assign ovf_w[2] = ifc.overflow;
  assign dout_w[3] = ifd.dout;  assign busy_w[3] = ifd.busy;  assign ovf_w[3] = ifd.overflow;
  assign pend_w[0] = ifa.pending;
  assign pend_w[1] = {8'h00, ifb.pending};
  assign pend_w[2] = ifc.pending;
  assign pend_w[3] = ifd.pending;

  typedef struct {
    int inst;
    int ch;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   pulses[16];
  logic prev_dout[16];
  bit   rand_mode = 1'b0;
  int   ins[4];
  int   outs[4];
  int   last_emit[4];

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int inst, input int ch, input int c);
    exp_t e;
    e.inst = inst;
    e.ch   = ch;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic set_din(input int inst, input logic [3:0] v);
    case (inst)
      0: ifa.din = v;
      1: ifb.din = v;
      2: ifc.din = v;
      default: ifd.din = v;
    endcase
  endtask

  function automatic int pend_ch(input int inst, input int ch);
    if (inst == 1) return int'((pend_w[1] >> (ch * 2)) & 16'h0003);
    return int'((pend_w[inst] >> (ch * 4)) & 16'h000F);
  endfunction

  // Monitor: every output event is matched against the oldest expectation
  // for that instance/channel; in random mode channel counts are tracked instead.
  always @(negedge clk) begin
    logic ev;
    int   idx;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (!nreset) begin
          prev_dout[i*4+c] = dout_w[i][c];
        end else begin
          ev = (i == 3) ? (dout_w[i][c] != prev_dout[i*4+c]) : dout_w[i][c];
          prev_dout[i*4+c] = dout_w[i][c];
          if (rand_mode && i == 0) begin
            check("rand_pending", pend_ch(0, c), ins[c] - outs[c]);
            if (ev) begin
              if (outs[c] > 0) check("rand_spacing", int'((cyc - last_emit[c]) >= 3), 1);
              last_emit[c] = cyc;
              outs[c]++;
            end
          end else if (ev) begin
            pulses[i*4+c]++;
            idx = -1;
            for (int k = 0; k < exp_q.size(); k++)
              if (idx < 0 && exp_q[k].inst == i && exp_q[k].ch == c) idx = k;
            check($sformatf("event_expected_i%0d_c%0d", i, c), int'(idx >= 0), 1);
            if (idx >= 0) begin
              check($sformatf("event_cycle_i%0d_c%0d", i, c), cyc, exp_q[idx].cyc);
              exp_q.delete(idx);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  int         t;
  int         p0;
  int         peak;
  logic [3:0] v;
  logic [7:0] lvl_tab;

  initial begin
    ifa.clr = 1'b0; ifb.clr = 1'b0; ifc.clr = 1'b0; ifd.clr = 1'b0;
    for (int i = 0; i < 4; i++) set_din(i, 4'h0);

    // Reset held with din toggling, then released.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) set_din(i, (k % 2 == 1) ? 4'hF : 4'h0);
      step();
    end
    for (int i = 0; i < 4; i++) set_din(i, 4'h0);
    check("rst_held_busy_a", int'(busy_w[0]), 0);
    nreset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_dout_%0d", i),    int'(dout_w[i]), 0);
      check($sformatf("rst_pending_%0d", i), int'(pend_w[i]), 0);
      check($sformatf("rst_busy_%0d", i),    int'(busy_w[i]), 0);
      check($sformatf("rst_ovf_%0d", i),     int'(ovf_w[i]),  0);
    end

    // Single event on a.ch0.
    t = cyc;
    push(0, 0, t + 1);
    ifa.din = 4'b0001;
    step();
    ifa.din = 4'b0000;
    check("single_pend_t1", pend_ch(0, 0), 1);
    check("single_busy_t1", int'(busy_w[0][0]), 1);
    step();
    check("single_pend_t2", pend_ch(0, 0), 0);
    check("single_busy_t2", int'(busy_w[0][0]), 1);
    step();
    check("single_busy_t3", int'(busy_w[0][0]), 1);
    step();
    check("single_busy_t4", int'(busy_w[0][0]), 0);
    for (int k = 0; k < 3; k++) step();

    // Burst of 5 on a.ch1: pulses every 3 cycles, peak pending 3.
    t = cyc;
    p0 = pulses[1];
    peak = 0;
    for (int k = 0; k < 5; k++) push(0, 1, t + 1 + 3 * k);
    for (int k = 0; k < 18; k++) begin
      ifa.din = (k < 5) ? 4'b0010 : 4'b0000;
      step();
      if (pend_ch(0, 1) > peak) peak = pend_ch(0, 1);
    end
    check("burst_peak", peak, 3);
    check("burst_count", pulses[1] - p0, 5);
    check("burst_pend_end", pend_ch(0, 1), 0);

    // Saturation on b.ch2 (CW=2): six events, one dropped.
    t = cyc;
    p0 = pulses[4 + 2];
    for (int k = 0; k < 5; k++) push(1, 2, t + 1 + 3 * k);
    for (int k = 0; k < 16; k++) begin
      ifb.din = (k < 6) ? 4'b0100 : 4'b0000;
      step();
      if (k == 4) check("sat_ovf_before", int'(ovf_w[1][2]), 0);
      if (k == 5) check("sat_ovf_set", int'(ovf_w[1][2]), 1);
    end
    check("sat_count", pulses[6] - p0, 5);
    check("sat_ovf_sticky", int'(ovf_w[1][2]), 1);
    ifb.clr = 1'b1;
    step();
    ifb.clr = 1'b0;
    check("sat_ovf_cleared", int'(ovf_w[1][2]), 0);

    // Second saturating burst with clr in the drop cycle: drop wins.
    t = cyc;
    for (int k = 0; k < 5; k++) push(1, 2, t + 1 + 3 * k);
    for (int k = 0; k < 16; k++) begin
      ifb.din = (k < 6) ? 4'b0100 : 4'b0000;
      ifb.clr = (k == 5);
      step();
      if (k == 5) check("sat_clr_vs_drop", int'(ovf_w[1][2]), 1);
    end
    ifb.clr = 1'b0;
    check("sat_other_ovf", int'(ovf_w[1] & 4'b1011), 0);

    // GAP=1 on c.ch3: continuous din, pending stays 1.
    t = cyc;
    for (int k = 0; k < 10; k++) push(2, 3, t + 1 + k);
    for (int k = 0; k < 12; k++) begin
      ifc.din = (k < 10) ? 4'b1000 : 4'b0000;
      step();
      if (k < 10)  check("gap1_pend", pend_ch(2, 3), 1);
      if (k == 10) check("gap1_pend_end", pend_ch(2, 3), 0);
    end
    check("gap1_ovf", int'(ovf_w[2]), 0);

    // MODE=1 GAP=2 on d.ch0: toggles at t+2, t+4, t+6.
    t = cyc;
    lvl_tab = 8'b1110_0110;
    push(3, 0, t + 2);
    push(3, 0, t + 4);
    push(3, 0, t + 6);
    for (int k = 0; k < 8; k++) begin
      ifd.din = (k < 3) ? 4'b0001 : 4'b0000;
      step();
      check($sformatf("tog_level_k%0d", k), int'(dout_w[3][0]), int'(lvl_tab[k]));
      check("tog_others", int'(dout_w[3][3:1]), 0);
    end

    // Random concurrent traffic on instance a against per-channel counters.
    for (int c = 0; c < 4; c++) begin
      ins[c] = 0;
      outs[c] = 0;
      last_emit[c] = 0;
    end
    rand_mode = 1'b1;
    for (int k = 0; k < 200; k++) begin
      v = 4'b0000;
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(7) == 0 && (ins[c] - outs[c]) < 10) begin
          v[c] = 1'b1;
          ins[c]++;
        end
      end
      ifa.din = v;
      step();
    end
    ifa.din = 4'b0000;
    for (int k = 0; k < 60; k++) step();
    for (int c = 0; c < 4; c++) check($sformatf("rand_total_c%0d", c), outs[c], ins[c]);
    check("rand_ovf", int'(ovf_w[0]), 0);
    check("rand_busy_end", int'(busy_w[0]), 0);
    rand_mode = 1'b0;
    step();

    // Reset asserted mid-burst, between clock edges.
    t = cyc;
    push(0, 0, t + 1);
    push(0, 0, t + 4);
    for (int k = 0; k < 6; k++) begin
      ifa.din = (k < 5) ? 4'b0001 : 4'b0000;
      step();
    end
    check("mid_pending_before", pend_ch(0, 0), 3);
    #2;
    nreset = 1'b0;
    #1;
    check("mid_pending_async", pend_ch(0, 0), 0);
    check("mid_busy_async", int'(busy_w[0]), 0);
    check("mid_dout_d_async", int'(dout_w[3]), 0);
    step();
    step();
    nreset = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("mid_pending_after", pend_ch(0, 0), 0);
    check("mid_busy_after", int'(busy_w[0]), 0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
